// File: rtl/id_ram_writer.sv
// ---------------------------------------------------------------------------
// id_ram_writer
//
// Enrollment controller for the user-ID store. It takes a new user ID from
// the entry logic, scans the IDs already held in the ID RAM for a duplicate,
// and writes the new ID into the next free slot. The single-port synchronous
// RAM (depth 2**ADDR_W, width ID_W) is owned exclusively by this block while
// busy. Entries are kept packed at addresses 0..id_count-1.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   req       in   one-cycle enroll request for id_in (sampled only in IDLE)
//   clr       in   one-cycle erase-all request (sampled only in IDLE, wins
//                  over req)
//   id_in     in   ID to enroll, valid with req
//   q         in   RAM read data for the address registered at the last edge
//   address   out  RAM address
//   data      out  RAM write data (always the latched ID)
//   wren      out  RAM write enable, high only in the WRITE state
//   busy      out  high whenever an operation is in progress
//   done      out  one-cycle pulse at the end of every accepted request
//   err_dup   out  last request rejected: ID already stored (sticky)
//   err_full  out  last request rejected: store full (sticky)
//   id_count  out  number of valid entries, 0..2**ADDR_W
// ---------------------------------------------------------------------------
module id_ram_writer #(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              clr,
    input  logic [ID_W-1:0]   id_in,
    input  logic [ID_W-1:0]   q,
    output logic [ADDR_W-1:0] address,
    output logic [ID_W-1:0]   data,
    output logic              wren,
    output logic              busy,
    output logic              done,
    output logic              err_dup,
    output logic              err_full,
    output logic [ADDR_W:0]   id_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_CMP   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int              DEPTH_I    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]      state_q,    state_d;
    logic [ADDR_W:0] idx_q,      idx_d;
    logic [ADDR_W:0] count_q,    count_d;
    logic [ID_W-1:0] id_reg_q,   id_reg_d;
    logic            err_dup_q,  err_dup_d;
    logic            err_full_q, err_full_d;

    logic [ADDR_W:0] idx_inc;

    assign idx_inc = idx_q + ONE;

    // Next-state logic. A scan visits entries 0..count-1 in RD/CMP pairs,
    // because the RAM returns data one edge after the address is presented.
    // An empty store skips the scan; a full store is rejected without any
    // RAM access.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        id_reg_d   = id_reg_q;
        err_dup_d  = err_dup_q;
        err_full_d = err_full_q;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    count_d    = '0;
                    err_dup_d  = 1'b0;
                    err_full_d = 1'b0;
                end else if (req) begin
                    id_reg_d   = id_in;
                    err_dup_d  = 1'b0;
                    err_full_d = 1'b0;
                    idx_d      = '0;
                    if (count_q == FULL_COUNT) begin
                        err_full_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (count_q == '0) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                state_d = S_CMP;
            end

            S_CMP: begin
                if (q == id_reg_q) begin
                    err_dup_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idx_d = idx_inc;
                    if (idx_inc == count_q) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_WRITE: begin
                count_d = count_q + ONE;
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state lives here; reset is asynchronous so every decoded output
    // (including wren) drops as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            id_reg_q   <= '0;
            err_dup_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            id_reg_q   <= id_reg_d;
            err_dup_q  <= err_dup_d;
            err_full_q <= err_full_d;
        end
    end

    // Outputs are decoded from the current state so the RAM sees the address
    // and write enable in the same cycle the state is entered. The write slot
    // is id_count itself since entries are packed from address 0.
    always_comb begin
        address = '0;
        case (state_q)
            S_RD:    address = idx_q[ADDR_W-1:0];
            S_WRITE: address = count_q[ADDR_W-1:0];
            default: address = '0;
        endcase
    end

    assign data     = id_reg_q;
    assign wren     = (state_q == S_WRITE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err_dup  = err_dup_q;
    assign err_full = err_full_q;
    assign id_count = count_q;

endmodule

// File: doc/id_ram_writer.md
# id_ram_writer

Enrollment-side controller for the user-ID store: accepts a new 16-bit user ID from the entry logic, scans the IDs already held in an on-chip ID RAM for a duplicate, and writes the ID into the next free slot. It is the writer counterpart to the ID read/lookup path. It sits between the keypad/ID entry FSM and a single-port synchronous RAM (8 x 16), which it owns exclusively while busy.

## Interface
Parameters:
- ID_W, 16, width of a user ID and RAM word
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W (8)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  single-cycle request to enroll id_in; sampled only in IDLE
- clr  in  1  single-cycle request to erase all entries (logical: count := 0); sampled only in IDLE
- id_in  in  ID_W  ID to enroll, valid with req
- q  in  ID_W  RAM read data; reflects address registered at previous clk edge
- address  out  ADDR_W  RAM address
- data  out  ID_W  RAM write data
- wren  out  1  RAM write enable
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of every accepted req
- err_dup  out  1  last request rejected, ID already stored
- err_full  out  1  last request rejected, store full
- id_count  out  ADDR_W+1  number of valid entries, 0..8

## Operation
- State register: IDLE, RD, CMP, WRITE, DONE. Registers: id_reg (latched id_in), idx (scan index, ADDR_W+1 bits), id_count.
- Reset (async, immediate): state=IDLE, id_count=0, idx=0, id_reg=0, address=0, data=0, wren=0, busy=0, done=0, err_dup=0, err_full=0.
- IDLE: clr=1 -> id_count:=0, stay IDLE. clr has priority; simultaneous req is dropped. req=1 (clr=0) -> latch id_in into id_reg, clear err_dup/err_full, idx:=0; then:
  - id_count==8 -> DONE with err_full:=1 (no scan, no write).
  - id_count==0 -> WRITE.
  - otherwise -> RD.
- RD: address=idx[ADDR_W-1:0]; -> CMP.
- CMP: q is valid for idx. q==id_reg -> err_dup:=1, DONE. Else idx:=idx+1; if idx+1==id_count -> WRITE else -> RD.
- WRITE: address=id_count[ADDR_W-1:0], data=id_reg, wren=1 for exactly this cycle; id_count:=id_count+1 at end of cycle; -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- data holds id_reg during the whole operation; wren is 0 in every state except WRITE.
- req/clr while busy are ignored (not queued). id_in is don't-care except on the accepting edge.
- err_dup/err_full are sticky until the next accepted req, clr, or reset; at most one is set per request; neither is set on a successful write.
- ID value 0 is a legal ID; no reserved values.

## Timing
- Notation: req sampled at edge 0; cycle n = period after edge n. k = id_count at acceptance.
- busy rises in cycle 1 and falls in the cycle after DONE.
- Scan: entry j is addressed in cycle 2j+1, compared in cycle 2j+2 (1-cycle RAM read latency).
- Success: wren in cycle 2k+1, done and new id_count visible in cycle 2k+2. k=0: wren cycle 1, done cycle 2.
- Duplicate at entry j: done and err_dup in cycle 2j+3; no write.
- Full (k=8): done and err_full in cycle 1.
- Next req is accepted earliest at the edge ending the first IDLE cycle after DONE.
- Reset mid-operation, including during WRITE: wren drops combinationally with rst, no partial count update, return to IDLE.

## Test plan
- After reset, req id_in=16'h1234 -> wren=1 at address 0 with data 16'h1234 in cycle 1, done in cycle 2, id_count=1, no error flags.
- Enroll 16'hA001..16'hA003, then req 16'hA002 -> no wren, err_dup=1 with done in cycle 5 (j=1), id_count stays 3.
- Enroll 8 distinct IDs, then req 16'hBEEF -> err_full=1 and done in cycle 1, no wren, id_count=8. Then clr -> id_count=0. Then req 16'hBEEF -> written at address 0.
- With id_count=3, req 16'h0000 -> addresses 0,1,2 read on cycles 1,3,5, wren at address 3 in cycle 7, done in cycle 8; a second req pulsed while busy is ignored.
- clr and req on the same edge in IDLE -> id_count=0, no operation started, busy stays 0.
- Assert rst during the RD state of a scan with id_count=4 -> all outputs return to reset values immediately, id_count=0, wren never asserted.
